// File: rtl/gp_register_file_mp.sv
// Parametrised multi-port general-purpose register file with priority write-back,
// same-cycle forwarding, a per-register busy scoreboard and a registered busy count.
module gp_register_file_mp #(
   parameter int XLEN      = 32,
   parameter int NUM_REGS  = 32,
   parameter int NUM_READ  = 2,
   parameter int NUM_WRITE = 2,
   parameter int ZERO_REG  = 1,
   localparam int IDXW     = $clog2(NUM_REGS),
   localparam int CNTW     = $clog2(NUM_REGS + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_READ*IDXW-1:0]  rd_idx,
   output logic [NUM_READ*XLEN-1:0]  rd_data,
   output logic [NUM_READ-1:0]       rd_busy,
   input  logic [NUM_WRITE-1:0]      wr_en,
   input  logic [NUM_WRITE*IDXW-1:0] wr_idx,
   input  logic [NUM_WRITE*XLEN-1:0] wr_data,
   input  logic                      busy_set_en,
   input  logic [IDXW-1:0]           busy_set_idx,
   output logic [CNTW-1:0]           busy_count
);

   localparam bit HAS_ZERO = (ZERO_REG != 0);

   logic [XLEN-1:0]     gp      [NUM_REGS];
   logic [XLEN-1:0]     gp_next [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;
   logic [CNTW-1:0]     cnt_next;

   // Ascending port order lets the highest-numbered port overwrite lower ones.
   always_comb begin
      gp_next   = gp;
      busy_next = busy;
      for (int w = 0; w < NUM_WRITE; w++) begin
         if (wr_en[w] && !(HAS_ZERO && wr_idx[w*IDXW +: IDXW] == '0)) begin
            gp_next[wr_idx[w*IDXW +: IDXW]]   = wr_data[w*XLEN +: XLEN];
            busy_next[wr_idx[w*IDXW +: IDXW]] = 1'b0;
         end
      end
      // A newly issued producer outranks the write-back retiring the old one.
      if (busy_set_en && !(HAS_ZERO && busy_set_idx == '0))
         busy_next[busy_set_idx] = 1'b1;
      cnt_next = '0;
      for (int i = 0; i < NUM_REGS; i++)
         cnt_next = cnt_next + CNTW'(busy_next[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            gp[i] <= '0;
         busy       <= '0;
         busy_count <= '0;
      end else begin
         gp         <= gp_next;
         busy       <= busy_next;
         busy_count <= cnt_next;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int r = 0; r < NUM_READ; r++) begin : rd_port
         logic [IDXW-1:0] idx;
         logic [XLEN-1:0] data;
         logic            hit;
         idx  = rd_idx[r*IDXW +: IDXW];
         data = gp[idx];
         hit  = 1'b0;
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w] && wr_idx[w*IDXW +: IDXW] == idx) begin
               data = wr_data[w*XLEN +: XLEN];
               hit  = 1'b1;
            end
         end
         if (reset || (HAS_ZERO && idx == '0)) begin
            rd_data[r*XLEN +: XLEN] = '0;
            rd_busy[r]              = 1'b0;
         end else begin
            rd_data[r*XLEN +: XLEN] = data;
            rd_busy[r]              = busy[idx] && !hit;
         end
      end
   end

endmodule

// File: tb/tb_gp_register_file_mp.sv
// Directed bench for gp_register_file_mp: default configuration plus a
// 64-bit / 16-entry / 3-read / 1-write / no-zero-register configuration.
module tb_gp_register_file_mp;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // default configuration
   logic [9:0]  rd_idx_a;
   logic [63:0] rd_data_a;
   logic [1:0]  rd_busy_a;
   logic [1:0]  wr_en_a;
   logic [9:0]  wr_idx_a;
   logic [63:0] wr_data_a;
   logic        busy_set_en_a;
   logic [4:0]  busy_set_idx_a;
   logic [5:0]  busy_count_a;

   // sweep configuration
   logic [11:0]  rd_idx_b;
   logic [191:0] rd_data_b;
   logic [2:0]   rd_busy_b;
   logic [0:0]   wr_en_b;
   logic [3:0]   wr_idx_b;
   logic [63:0]  wr_data_b;
   logic         busy_set_en_b;
   logic [3:0]   busy_set_idx_b;
   logic [4:0]   busy_count_b;

   int checks = 0;
   int errors = 0;

   gp_register_file_mp dut_a (
      .clk(clk), .reset(reset),
      .rd_idx(rd_idx_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .wr_en(wr_en_a), .wr_idx(wr_idx_a), .wr_data(wr_data_a),
      .busy_set_en(busy_set_en_a), .busy_set_idx(busy_set_idx_a),
      .busy_count(busy_count_a)
   );

   gp_register_file_mp #(
      .XLEN(64), .NUM_REGS(16), .NUM_READ(3), .NUM_WRITE(1), .ZERO_REG(0)
   ) dut_b (
      .clk(clk), .reset(reset),
      .rd_idx(rd_idx_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en_b), .wr_idx(wr_idx_b), .wr_data(wr_data_b),
      .busy_set_en(busy_set_en_b), .busy_set_idx(busy_set_idx_b),
      .busy_count(busy_count_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en_a = '0; wr_idx_a = '0; wr_data_a = '0;
      busy_set_en_a = 1'b0; busy_set_idx_a = '0;
      wr_en_b = '0; wr_idx_b = '0; wr_data_b = '0;
      busy_set_en_b = 1'b0; busy_set_idx_b = '0;
   endtask

   task automatic test_reset();
      // preload gp[5] and busy[5]
      wr_en_a = 2'b01; wr_idx_a = {5'd0, 5'd5}; wr_data_a = {32'h0, 32'hDEADBEEF};
      busy_set_en_a = 1'b1; busy_set_idx_a = 5'd5;
      tick(); idle();
      rd_idx_a = {5'd3, 5'd5};
      #1;
      checks++;
      if (rd_data_a[31:0] !== 32'hDEADBEEF || rd_busy_a[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_preload got data %h busy %b exp DEADBEEF 1", rd_data_a[31:0], rd_busy_a[0]);
      end
      checks++;
      if (busy_count_a !== 6'd1) begin
         errors++;
         $display("FAIL reset_preload_count got %0d exp 1", busy_count_a);
      end
      // reset cycle with a competing write to idx 3
      reset = 1'b1;
      wr_en_a = 2'b01; wr_idx_a = {5'd0, 5'd3}; wr_data_a = {32'h0, 32'h11};
      #1;
      checks++;
      if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00) begin
         errors++;
         $display("FAIL reset_override got data %h busy %b exp 0 00", rd_data_a, rd_busy_a);
      end
      tick(); idle(); reset = 1'b0;
      #1;
      checks++;
      if (rd_data_a[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL reset_gp5 got %h exp 0", rd_data_a[31:0]);
      end
      checks++;
      if (rd_data_a[63:32] !== 32'h0) begin
         errors++;
         $display("FAIL reset_gp3_write_dropped got %h exp 0", rd_data_a[63:32]);
      end
      checks++;
      if (rd_busy_a !== 2'b00) begin
         errors++;
         $display("FAIL reset_busy got %b exp 00", rd_busy_a);
      end
      checks++;
      if (busy_count_a !== 6'd0) begin
         errors++;
         $display("FAIL reset_count got %0d exp 0", busy_count_a);
      end
   endtask

   task automatic test_zero_reg();
      rd_idx_a = {5'd0, 5'd0};
      wr_en_a = 2'b01; wr_idx_a = {5'd0, 5'd0}; wr_data_a = {32'h0, 32'h1234};
      busy_set_en_a = 1'b1; busy_set_idx_a = 5'd0;
      #1;
      checks++;
      if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00) begin
         errors++;
         $display("FAIL zero_same_cycle got data %h busy %b exp 0 00", rd_data_a, rd_busy_a);
      end
      tick(); idle();
      #1;
      checks++;
      if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00) begin
         errors++;
         $display("FAIL zero_after got data %h busy %b exp 0 00", rd_data_a, rd_busy_a);
      end
      checks++;
      if (busy_count_a !== 6'd0) begin
         errors++;
         $display("FAIL zero_count got %0d exp 0", busy_count_a);
      end
   endtask

   task automatic test_forward_priority();
      rd_idx_a = {5'd7, 5'd7};
      wr_en_a = 2'b11; wr_idx_a = {5'd7, 5'd7};
      wr_data_a = {32'h5555FFFF, 32'hAAAA0000};
      #1;
      checks++;
      if (rd_data_a !== {32'h5555FFFF, 32'h5555FFFF}) begin
         errors++;
         $display("FAIL fwd_priority got %h exp 5555ffff5555ffff", rd_data_a);
      end
      checks++;
      if (rd_busy_a !== 2'b00) begin
         errors++;
         $display("FAIL fwd_busy got %b exp 00", rd_busy_a);
      end
      tick(); idle();
      #1;
      checks++;
      if (rd_data_a !== {32'h5555FFFF, 32'h5555FFFF}) begin
         errors++;
         $display("FAIL fwd_stored got %h exp 5555ffff5555ffff", rd_data_a);
      end
   endtask

   task automatic test_scoreboard();
      rd_idx_a = {5'd7, 5'd9};
      busy_set_en_a = 1'b1; busy_set_idx_a = 5'd9;
      tick(); idle();
      #1;
      checks++;
      if (rd_busy_a !== 2'b01) begin
         errors++;
         $display("FAIL sb_set_busy got %b exp 01", rd_busy_a);
      end
      checks++;
      if (busy_count_a !== 6'd1) begin
         errors++;
         $display("FAIL sb_set_count got %0d exp 1", busy_count_a);
      end
      wr_en_a = 2'b01; wr_idx_a = {5'd0, 5'd9}; wr_data_a = {32'h0, 32'h42};
      #1;
      checks++;
      if (rd_busy_a[0] !== 1'b0 || rd_data_a[31:0] !== 32'h42) begin
         errors++;
         $display("FAIL sb_writeback got busy %b data %h exp 0 42", rd_busy_a[0], rd_data_a[31:0]);
      end
      checks++;
      if (busy_count_a !== 6'd1) begin
         errors++;
         $display("FAIL sb_count_lag got %0d exp 1", busy_count_a);
      end
      tick(); idle();
      #1;
      checks++;
      if (busy_count_a !== 6'd0 || rd_busy_a !== 2'b00) begin
         errors++;
         $display("FAIL sb_cleared got count %0d busy %b exp 0 00", busy_count_a, rd_busy_a);
      end
      checks++;
      if (rd_data_a[31:0] !== 32'h42) begin
         errors++;
         $display("FAIL sb_data got %h exp 42", rd_data_a[31:0]);
      end
   endtask

   task automatic test_set_clear_collision();
      rd_idx_a = {5'd7, 5'd4};
      busy_set_en_a = 1'b1; busy_set_idx_a = 5'd4;
      tick(); idle();
      #1;
      checks++;
      if (busy_count_a !== 6'd1 || rd_busy_a[0] !== 1'b1) begin
         errors++;
         $display("FAIL coll_pre got count %0d busy %b exp 1 1", busy_count_a, rd_busy_a[0]);
      end
      wr_en_a = 2'b10; wr_idx_a = {5'd4, 5'd0}; wr_data_a = {32'h77, 32'h0};
      busy_set_en_a = 1'b1; busy_set_idx_a = 5'd4;
      #1;
      checks++;
      if (rd_busy_a[0] !== 1'b0 || rd_data_a[31:0] !== 32'h77) begin
         errors++;
         $display("FAIL coll_forward got busy %b data %h exp 0 77", rd_busy_a[0], rd_data_a[31:0]);
      end
      tick(); idle();
      #1;
      checks++;
      if (rd_busy_a[0] !== 1'b1 || busy_count_a !== 6'd1) begin
         errors++;
         $display("FAIL coll_set_wins got busy %b count %0d exp 1 1", rd_busy_a[0], busy_count_a);
      end
      checks++;
      if (rd_data_a[31:0] !== 32'h77) begin
         errors++;
         $display("FAIL coll_data got %h exp 77", rd_data_a[31:0]);
      end
   endtask

   task automatic test_param_sweep();
      rd_idx_b = {4'd0, 4'd0, 4'd0};
      wr_en_b = 1'b1; wr_idx_b = 4'd0; wr_data_b = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      checks++;
      if (rd_data_b !== {192{1'b1}}) begin
         errors++;
         $display("FAIL sweep_fwd got %h exp all ones", rd_data_b);
      end
      tick(); idle();
      #1;
      for (int r = 0; r < 3; r++) begin
         checks++;
         if (rd_data_b[r*64 +: 64] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL sweep_read port %0d got %h exp ffffffffffffffff", r, rd_data_b[r*64 +: 64]);
         end
      end
      for (int i = 0; i < 16; i++) begin
         busy_set_en_b = 1'b1; busy_set_idx_b = 4'(i);
         tick();
      end
      idle();
      rd_idx_b = {4'd15, 4'd8, 4'd0};
      #1;
      checks++;
      if (busy_count_b !== 5'd16) begin
         errors++;
         $display("FAIL sweep_count got %0d exp 16", busy_count_b);
      end
      checks++;
      if (rd_busy_b !== 3'b111) begin
         errors++;
         $display("FAIL sweep_busy got %b exp 111", rd_busy_b);
      end
   endtask

   initial begin
      reset = 1'b1;
      rd_idx_a = '0;
      rd_idx_b = '0;
      idle();
      repeat (3) tick();
      reset = 1'b0;
      test_reset();
      test_zero_reg();
      test_forward_priority();
      test_scoreboard();
      test_set_clear_collision();
      test_param_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gp_register_file_mp.md
Name: gp_register_file_mp

Overview:
- Parametrised multi-port general-purpose register file, successor to the fixed 2-read/1-write GP file in the decode stage.
- Adds configurable width, depth and port counts, plus multiple write-back ports with priority.
- Same-cycle write-to-read forwarding is kept.
- Adds a per-register busy scoreboard for pending writes, a registered busy counter, and synchronous clear of all architectural state.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of registers; power of two, at least 2. IDXW = clog2(NUM_REGS).
- NUM_READ, 2, number of read ports, at least 1.
- NUM_WRITE, 2, number of write ports, at least 1. Higher index has higher priority.
- ZERO_REG, 1. When 1, register 0 is hardwired to zero, never written and never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_idx  in  NUM_READ*IDXW  read indices; port r uses slice [r*IDXW +: IDXW].
- rd_data  out  NUM_READ*XLEN  read data, combinational.
- rd_busy  out  NUM_READ  register still awaiting its pending write, combinational.
- wr_en  in  NUM_WRITE  write enables.
- wr_idx  in  NUM_WRITE*IDXW  write indices.
- wr_data  in  NUM_WRITE*XLEN  write data.
- busy_set_en  in  1  mark a register busy (a producer was issued).
- busy_set_idx  in  IDXW  register to mark busy.
- busy_count  out  clog2(NUM_REGS+1)  registered count of busy registers.

Behaviour:
- Reset, synchronous and active-high, sampled on the rising edge of clk:
  - All registers become 0, all busy bits 0, busy_count 0.
  - Reset dominates every write and busy_set in that cycle.
- While reset is high: rd_data is forced to 0 and rd_busy to 0 (combinational override). Reset asserted mid-stream discards all pending state.
- Write:
  - On the edge, each port w with wr_en[w]=1 writes wr_data[w] to gp[wr_idx[w]].
  - Same index on several enabled ports: the highest-numbered port wins; the others are dropped silently.
  - With ZERO_REG=1, writes to index 0 are ignored.
- Read, zero latency:
  - ZERO_REG=1 and idx 0: data 0.
  - Otherwise, any enabled write port matches idx: data from the highest-numbered matching port (forwarding).
  - Otherwise: data is gp[idx].
  - Every read port resolves independently; all may use the same index.
- Scoreboard:
  - busy bit set on the edge when busy_set_en=1 (ignored for idx 0 when ZERO_REG=1).
  - busy bit cleared on the edge when any enabled write port targets that index.
  - Set and clear on the same index in the same cycle: set wins (a new producer is outstanding).
- rd_busy[r] = busy[idx] AND no enabled write port matches idx this cycle.
  - A forwarded value is therefore reported not busy.
  - Idx 0 is always 0 when ZERO_REG=1.
- busy_count:
  - Registered popcount of the busy vector after the edge.
  - Shows the next-state busy vector one cycle after the update, never wraps, range 0..NUM_REGS (NUM_REGS-1 when ZERO_REG=1).
- No handshake stalls: every port is accepted every cycle. There is no error output for write collisions.
- Contents are undefined only before the first reset. The bench always resets first.

Test Plan:
- Reset: preload gp[5]=0xDEADBEEF with busy[5]=1, then hold reset 1 cycle -> rd_data for idx 5 = 0, rd_busy=0, busy_count=0. During that reset cycle wr_en[0] to idx 3 with 0x11 -> gp[3] still reads 0 afterwards.
- Zero register: write 0x1234 to idx 0 on port 0 and set busy on idx 0 -> rd idx 0 = 0 in the same cycle and after; rd_busy=0; busy_count unchanged.
- Forwarding and priority:
  - Port 0 writes idx 7 with 0xAAAA0000 while port 1 writes idx 7 with 0x5555FFFF, read ports 0 and 1 both reading idx 7 -> both return 0x5555FFFF that cycle.
  - gp[7]=0x5555FFFF next cycle.
- Scoreboard lifecycle:
  - Set busy idx 9 -> next cycle rd_busy=1 and busy_count=1.
  - Write-back 0x42 to idx 9 -> same cycle rd_busy=0 and data 0x42; next cycle busy_count=0.
- Set/clear collision: busy[4]=1, then in one cycle write idx 4 and busy_set idx 4 -> busy[4] stays 1, busy_count stays 1, gp[4] updated.
- Parameter sweep: XLEN=64, NUM_REGS=16, NUM_READ=3, NUM_WRITE=1, ZERO_REG=0:
  - Write 0xFFFF_FFFF_FFFF_FFFF to idx 0 -> reads back the full 64-bit value on all 3 ports.
  - Set busy on all 16 registers -> busy_count=16.
